// File: rtl/cpu_pkg.sv
// Shared CPU definitions: condition codes, NZCV flag bit positions and
// FlagWrite bit positions used by the execute-stage condition logic.
package cpu_pkg;

  typedef enum logic [3:0] {
    EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
    MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
    HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
    GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
  } cond_t;

  localparam int N_IDX = 3;
  localparam int Z_IDX = 2;
  localparam int C_IDX = 1;
  localparam int V_IDX = 0;

  localparam int FW_NZ = 1;
  localparam int FW_CV = 0;

endpackage

// File: rtl/cond_unit_e_if.sv
// Execute-stage condition unit bundle: pipeline control bits in, gated
// controls, current flags and performance counters out.
interface cond_unit_e_if #(parameter int CNT_W = 16);
  logic             StallE;
  logic             clr_cnt;
  logic [3:0]       CondE;
  logic [1:0]       FlagWriteE;
  logic [3:0]       ALUFlags;
  logic             PCSrcE;
  logic             RegWriteE;
  logic             MemWriteE;
  logic             BranchE;
  logic             CondExE;
  logic             PCSrcGE;
  logic             RegWriteGE;
  logic             MemWriteGE;
  logic             BranchTakenE;
  logic [3:0]       FlagsD;
  logic [CNT_W-1:0] ExecCnt;
  logic [CNT_W-1:0] SquashCnt;

  modport master (
    output StallE, clr_cnt, CondE, FlagWriteE, ALUFlags,
           PCSrcE, RegWriteE, MemWriteE, BranchE,
    input  CondExE, PCSrcGE, RegWriteGE, MemWriteGE, BranchTakenE,
           FlagsD, ExecCnt, SquashCnt
  );

  modport slave (
    input  StallE, clr_cnt, CondE, FlagWriteE, ALUFlags,
           PCSrcE, RegWriteE, MemWriteE, BranchE,
    output CondExE, PCSrcGE, RegWriteGE, MemWriteGE, BranchTakenE,
           FlagsD, ExecCnt, SquashCnt
  );
endinterface

// File: rtl/cond_check.sv
// Combinational condition-code evaluator against an NZCV flag vector;
// shared by any stage that needs to resolve a condition field.
module cond_check
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[N_IDX];
  assign z = flags[Z_IDX];
  assign c = flags[C_IDX];
  assign v = flags[V_IDX];

  always_comb begin
    pass = 1'b0;
    case (cond_t'(cond))
      EQ: pass = z;
      NE: pass = ~z;
      CS: pass = c;
      CC: pass = ~c;
      MI: pass = n;
      PL: pass = ~n;
      VS: pass = v;
      VC: pass = ~v;
      HI: pass = c & ~z;
      LS: pass = ~c | z;
      GE: pass = (n == v);
      LT: pass = (n != v);
      GT: pass = ~z & (n == v);
      LE: pass = z | (n != v);
      AL: pass = 1'b1;
      NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit_e.sv
// Execute-stage condition unit: owns the NZCV flags, gates write/branch
// controls by the condition result and counts executed/squashed instructions.
module cond_unit_e
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic           clk,
  input logic           reset,
  cond_unit_e_if.slave  bus
);

  logic [3:0]       flags;
  logic             cond_ex;
  logic             active;
  logic             advance;
  logic [CNT_W-1:0] exec_cnt;
  logic [CNT_W-1:0] squash_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    return (&val) ? val : val + CNT_W'(1);
  endfunction

  cond_check u_cond_check (
    .cond  (bus.CondE),
    .flags (flags),
    .pass  (cond_ex)
  );

  // A flushed bubble carries no control bits and must not be counted.
  assign active  = bus.PCSrcE | bus.RegWriteE | bus.MemWriteE | bus.BranchE |
                   (|bus.FlagWriteE);
  assign advance = ~bus.StallE;

  assign bus.CondExE      = cond_ex;
  assign bus.PCSrcGE      = bus.PCSrcE    & cond_ex;
  assign bus.RegWriteGE   = bus.RegWriteE & cond_ex;
  assign bus.MemWriteGE   = bus.MemWriteE & cond_ex;
  assign bus.BranchTakenE = bus.BranchE   & cond_ex;
  assign bus.FlagsD       = flags;
  assign bus.ExecCnt      = exec_cnt;
  assign bus.SquashCnt    = squash_cnt;

  // Flags register: written at the end of the cycle so the next instruction
  // sees the new value directly, no bypass needed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags <= 4'b0000;
    end else if (cond_ex && advance) begin
      if (bus.FlagWriteE[FW_NZ]) begin
        flags[N_IDX] <= bus.ALUFlags[N_IDX];
        flags[Z_IDX] <= bus.ALUFlags[Z_IDX];
      end
      if (bus.FlagWriteE[FW_CV]) begin
        flags[C_IDX] <= bus.ALUFlags[C_IDX];
        flags[V_IDX] <= bus.ALUFlags[V_IDX];
      end
    end
  end

  // Performance counters; clear wins over increment and ignores the stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exec_cnt   <= '0;
      squash_cnt <= '0;
    end else if (bus.clr_cnt) begin
      exec_cnt   <= '0;
      squash_cnt <= '0;
    end else if (advance && active) begin
      if (cond_ex) exec_cnt   <= sat_inc(exec_cnt);
      else         squash_cnt <= sat_inc(squash_cnt);
    end
  end

endmodule

// File: doc/cond_unit_e.md
Name: cond_unit_e

Overview:
- Execute-stage condition unit; consumes the decode/execute pipeline register outputs (CondE, FlagWriteE and the raw control bits).
- Owns the architectural NZCV flags register and evaluates the condition code against it.
- Gates the write/branch controls sent to the memory stage and fetch, and drives FlagsD back into the decode/execute register.
- Keeps saturating counters of executed and squashed instructions for performance debug.

Parameters:
CNT_W, 16, width of the executed/squashed instruction counters

Ports:
clk  in  1  system clock, rising edge
reset  in  1  reset; asynchronous, active-high; clears flags and counters
StallE  in  1  execute stage held; blocks flag update and counting
clr_cnt  in  1  synchronous clear of both counters
CondE  in  4  condition field of the instruction in E
FlagWriteE  in  2  bit1 = write N,Z; bit0 = write C,V
ALUFlags  in  4  ALU result flags {N,Z,C,V}
PCSrcE  in  1  ungated PC-write request
RegWriteE  in  1  ungated register write
MemWriteE  in  1  ungated memory write
BranchE  in  1  instruction is a branch
CondExE  out  1  condition passed
PCSrcGE  out  1  PCSrcE & CondExE
RegWriteGE  out  1  RegWriteE & CondExE
MemWriteGE  out  1  MemWriteE & CondExE
BranchTakenE  out  1  BranchE & CondExE
FlagsD  out  4  current flags register {N,Z,C,V}
ExecCnt  out  CNT_W  active instructions whose condition passed
SquashCnt  out  CNT_W  active instructions whose condition failed

Behaviour:
- Reset (async, any cycle, including mid-stall): flags = 4'b0000 and ExecCnt = SquashCnt = 0 immediately. Combinational outputs follow their inputs and the cleared flags.
- CondExE is combinational, computed from CondE and the flags register (not from ALUFlags).
- Condition encoding:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C&!Z
  - 9 LS: !C|Z
  - A GE: N==V
  - B LT: N!=V
  - C GT: !Z&(N==V)
  - D LE: Z|(N!=V)
  - E AL: 1
  - F: 0 (never executes)
- Gated outputs are zero-latency ANDs with CondExE. They are not affected by StallE.
- Flag update happens at posedge when CondExE & !StallE:
  - FlagWriteE[1] loads N,Z from ALUFlags[3:2].
  - FlagWriteE[0] loads C,V from ALUFlags[1:0].
  - Bits not selected hold their value.
- Condition failed: no flag update, regardless of FlagWriteE.
- Flag latency: a write is visible on FlagsD and to CondExE in the next cycle, so a flag-setting instruction followed directly by a conditional instruction resolves correctly with no bypass.
- Active instruction: any of PCSrcE, RegWriteE, MemWriteE, BranchE, FlagWriteE is nonzero. A flushed bubble (all zero) is inactive.
- Counting at posedge, when !StallE and active:
  - CondExE = 1: ExecCnt increments.
  - CondExE = 0: SquashCnt increments.
- Counters saturate at 2^CNT_W-1 and hold.
- clr_cnt takes priority over increment: both counters go to 0 and the instruction in that cycle is not counted. clr_cnt acts even while StallE = 1.
- StallE = 1 for N cycles, then released: exactly one flag update and one count for the held instruction.

Decomposition:
- Shared package cpu_pkg holds:
  - the cond_t enum (4-bit codes EQ..AL, NV = 4'hF);
  - flag index constants N_IDX = 3, Z_IDX = 2, C_IDX = 1, V_IDX = 0;
  - FW_NZ = 1 and FW_CV = 0 bit positions for FlagWrite.
- One combinational sub-module, cond_check (inputs cond, flags; output pass), reused by any later flag-consuming stage.

Test Plan:
- Reset mid-operation: flags = 1111, counters = 5; assert reset between clock edges → FlagsD = 0000, ExecCnt = SquashCnt = 0 before the next edge.
- CMP then BEQ: cycle 1 CondE = E, FlagWriteE = 11, ALUFlags = 0110 → cycle 2 FlagsD = 0110. Cycle 2 CondE = 0, BranchE = 1, PCSrcE = 1 → CondExE = 1, BranchTakenE = 1, PCSrcGE = 1; ExecCnt = 2.
- Squash: flags = 0110; CondE = 1 (NE), RegWriteE = 1, FlagWriteE = 11, ALUFlags = 1000 → CondExE = 0, RegWriteGE = 0, FlagsD stays 0110, SquashCnt +1.
- Partial write and bubble:
  - flags = 0000, CondE = E, FlagWriteE = 10, ALUFlags = 1111 → FlagsD = 1100.
  - Then an all-zero bubble → counters unchanged, FlagsD = 1100.
- Stall: StallE = 1 for 3 cycles with CondE = E, FlagWriteE = 11, ALUFlags = 0001 → FlagsD and ExecCnt unchanged, RegWriteGE follows RegWriteE. Release → FlagsD = 0001 and ExecCnt +1, exactly once.
- Saturation with CNT_W = 4: 20 consecutive active AL instructions → ExecCnt = 15 and holds. Then clr_cnt with an active AL instruction in the same cycle → ExecCnt = 0.
